shift_register_ctrl: RTL and testbench

Upstream sequencer for the 4-bit universal shift register (selects s1/s0, serial fills, parallel load, clock CLK). Accepts a word plus direction command over a valid/ready handshake and drives the register's select, serial-fill and parallel-load inputs to perform one parallel load followed by WIDTH shifts. It reads the register's A_par output back and presents the outgoing bit as a serial stream with its own valid/ready handshake. It pulses done when the word has fully shifted out.

---
 rtl/shift_register_ctrl_pkg.sv | 23 ++
 rtl/universal_shift_register.sv | 37 +++
 rtl/shift_register_ctrl.sv | 125 ++++++++++++
 tb/tb_shift_register_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_register_ctrl_pkg.sv
// rtl/shift_register_ctrl_pkg.sv - shared constants and state encoding for the shift register sequencer
// Contents:
//   SEL_*   : {s1,s0} select codes understood by the universal shift register
//   DIR_*   : command direction encoding (0 = right/LSB first, 1 = left/MSB first)
//   state_t : sequencer states
package shift_register_ctrl_pkg;

    localparam logic [1:0] SEL_HOLD  = 2'b00;
    localparam logic [1:0] SEL_RIGHT = 2'b01;
    localparam logic [1:0] SEL_LEFT  = 2'b10;
    localparam logic [1:0] SEL_LOAD  = 2'b11;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - 4-bit universal shift register driven by the sequencer
// Ports:
//   CLK            : clock, all updates on posedge
//   Clear_b        : synchronous active-low clear
//   s1, s0         : select 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   MSB_in, LSB_in : serial fill for right shift (into MSB) / left shift (into LSB)
//   I_par          : parallel-load word
//   A_par          : register contents
module universal_shift_register
    import shift_register_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             s1,
    input  logic             s0,
    input  logic             MSB_in,
    input  logic             LSB_in,
    input  logic [WIDTH-1:0] I_par,
    output logic [WIDTH-1:0] A_par
);

    always_ff @(posedge CLK) begin
        if (!Clear_b) begin
            A_par <= '0;
        end else begin
            case ({s1, s0})
                SEL_RIGHT: A_par <= {MSB_in, A_par[WIDTH-1:1]};
                SEL_LEFT:  A_par <= {A_par[WIDTH-2:0], LSB_in};
                SEL_LOAD:  A_par <= I_par;
                default:   A_par <= A_par;
            endcase
        end
    end

endmodule

// File: rtl/shift_register_ctrl.sv
// rtl/shift_register_ctrl.sv - sequencer: loads a word into the universal shift register and streams it out serially
// Ports:
//   CLK, Clear                     : clock and synchronous active-high reset
//   cmd_valid/cmd_ready            : command handshake; cmd_data/cmd_dir/cmd_fill captured on accept
//   A_par                          : register contents read back
//   s1, s0, I_par, MSB_in, LSB_in  : register control (select, load word, serial fills)
//   ser_out/ser_valid/ser_ready    : outgoing bit stream handshake
//   busy, done                     : not-idle flag and one-cycle completion pulse
module shift_register_ctrl
    import shift_register_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic             cmd_fill,
    input  logic [WIDTH-1:0] A_par,
    output logic             s1,
    output logic             s0,
    output logic [WIDTH-1:0] I_par,
    output logic             MSB_in,
    output logic             LSB_in,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_dir;
    logic             r_fill;
    logic [1:0]       w_sel;

    always_ff @(posedge CLK) begin
        if (Clear) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_dir   <= 1'b0;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    // cmd_ready is simply "IDLE and not Clear", so valid alone is an accept here
                    if (cmd_valid) begin
                        r_data <= cmd_data;
                        r_dir  <= cmd_dir;
                        r_fill <= cmd_fill;
                    end
                end
                LOAD: r_cnt <= '0;
                SHIFT: begin
                    if (ser_ready) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        w_sel     = SEL_HOLD;
        cmd_ready = 1'b0;
        ser_valid = 1'b0;
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = LOAD;
                end
            end
            LOAD: begin
                w_sel  = SEL_LOAD;
                w_next = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
                // A stalled beat holds the register so ser_out stays on the same bit
                if (ser_ready) begin
                    w_sel = (r_dir == DIR_LEFT) ? SEL_LEFT : SEL_RIGHT;
                    if (r_cnt == LP_LAST) begin
                        w_next = DONE;
                    end
                end
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Clear silences every output in the same cycle, whatever the current state
        if (Clear) begin
            w_next    = IDLE;
            w_sel     = SEL_HOLD;
            cmd_ready = 1'b0;
            ser_valid = 1'b0;
            done      = 1'b0;
        end
    end

    assign s1      = w_sel[1];
    assign s0      = w_sel[0];
    assign I_par   = r_data;
    assign MSB_in  = r_fill;
    assign LSB_in  = r_fill;
    assign ser_out = (r_dir == DIR_LEFT) ? A_par[WIDTH-1] : A_par[0];
    assign busy    = (r_state != IDLE) && !Clear;

endmodule

// File: tb/tb_shift_register_ctrl.sv
// tb/tb_shift_register_ctrl.sv - self-checking bench for shift_register_ctrl with the universal shift register
module tb_shift_register_ctrl;

    logic       CLK = 1'b0;
    logic       Clear;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_data;
    logic       cmd_dir;
    logic       cmd_fill;
    logic [3:0] A_par;
    logic       s1, s0;
    logic [3:0] I_par;
    logic       MSB_in, LSB_in;
    logic       ser_out, ser_valid, ser_ready;
    logic       busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    shift_register_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
        .CLK       (CLK),
        .Clear     (Clear),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_dir   (cmd_dir),
        .cmd_fill  (cmd_fill),
        .A_par     (A_par),
        .s1        (s1),
        .s0        (s0),
        .I_par     (I_par),
        .MSB_in    (MSB_in),
        .LSB_in    (LSB_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_ready (ser_ready),
        .busy      (busy),
        .done      (done)
    );

    universal_shift_register #(.WIDTH(4)) u_reg (
        .CLK     (CLK),
        .Clear_b (~Clear),
        .s1      (s1),
        .s0      (s0),
        .MSB_in  (MSB_in),
        .LSB_in  (LSB_in),
        .I_par   (I_par),
        .A_par   (A_par)
    );

    typedef struct {
        logic [3:0] data;
        logic       dir;
        logic       fill;
        logic [3:0] bits;   // bits[i] = i-th bit emitted
        logic [1:0] sel;    // select seen on every shifting beat
        logic [3:0] fin;    // register contents after the last shift
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic look();
        @(negedge CLK);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        tick();
        cmd_valid = 1'b1;
        cmd_data  = v.data;
        cmd_dir   = v.dir;
        cmd_fill  = v.fill;
        look();
        chk($sformatf("v%0d_ready_idle", idx), {7'b0, cmd_ready}, 8'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
        look();
        chk($sformatf("v%0d_load_sel", idx), {6'b0, s1, s0}, 8'd3);
        chk($sformatf("v%0d_load_ready", idx), {7'b0, cmd_ready}, 8'd0);
        chk($sformatf("v%0d_load_busy", idx), {7'b0, busy}, 8'd1);
        chk($sformatf("v%0d_ipar", idx), {4'b0, I_par}, {4'b0, v.data});
        for (int i = 0; i < 4; i++) begin
            tick();
            look();
            chk($sformatf("v%0d_valid%0d", idx, i), {7'b0, ser_valid}, 8'd1);
            chk($sformatf("v%0d_bit%0d", idx, i), {7'b0, ser_out}, {7'b0, v.bits[i]});
            chk($sformatf("v%0d_sel%0d", idx, i), {6'b0, s1, s0}, {6'b0, v.sel});
            chk($sformatf("v%0d_nodone%0d", idx, i), {7'b0, done}, 8'd0);
        end
        tick();
        look();
        chk($sformatf("v%0d_done", idx), {7'b0, done}, 8'd1);
        chk($sformatf("v%0d_done_sel", idx), {6'b0, s1, s0}, 8'd0);
        chk($sformatf("v%0d_done_ready", idx), {7'b0, cmd_ready}, 8'd0);
        chk($sformatf("v%0d_final", idx), {4'b0, A_par}, {4'b0, v.fin});
        chk($sformatf("v%0d_ipar_stable", idx), {4'b0, I_par}, {4'b0, v.data});
        tick();
        look();
        chk($sformatf("v%0d_done_once", idx), {7'b0, done}, 8'd0);
        chk($sformatf("v%0d_ready_back", idx), {7'b0, cmd_ready}, 8'd1);
        chk($sformatf("v%0d_idle_busy", idx), {7'b0, busy}, 8'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_b;

        vecs[0] = '{data: 4'b1010, dir: 1'b0, fill: 1'b0, bits: 4'b1010, sel: 2'b01, fin: 4'b0000};
        vecs[1] = '{data: 4'b1010, dir: 1'b1, fill: 1'b1, bits: 4'b0101, sel: 2'b10, fin: 4'b1111};
        vecs[2] = '{data: 4'b0110, dir: 1'b0, fill: 1'b1, bits: 4'b0110, sel: 2'b01, fin: 4'b1111};
        vecs[3] = '{data: 4'b1100, dir: 1'b1, fill: 1'b0, bits: 4'b0011, sel: 2'b10, fin: 4'b0000};

        Clear     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 4'h0;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        ser_ready = 1'b1;

        // reset
        look();
        chk("rst_ready", {7'b0, cmd_ready}, 8'd0);
        chk("rst_sel", {6'b0, s1, s0}, 8'd0);
        chk("rst_valid", {7'b0, ser_valid}, 8'd0);
        chk("rst_done", {7'b0, done}, 8'd0);
        chk("rst_busy", {7'b0, busy}, 8'd0);
        tick();
        Clear = 1'b0;
        look();
        chk("post_rst_ready", {7'b0, cmd_ready}, 8'd1);
        chk("post_rst_ipar", {4'b0, I_par}, 8'd0);
        chk("post_rst_busy", {7'b0, busy}, 8'd0);
        chk("post_rst_apar", {4'b0, A_par}, 8'd0);

        // table-driven transfers
        for (int v = 0; v < 4; v++) begin
            run_vec(vecs[v], v);
        end

        // stall: 0110 right, ser_ready low for 3 cycles on the 2nd bit
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 4'b0110;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        look();
        tick();
        cmd_valid = 1'b0;
        look();
        chk("stall_load_sel", {6'b0, s1, s0}, 8'd3);
        tick();
        look();
        chk("stall_bit0", {7'b0, ser_out}, 8'd0);
        tick();
        ser_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            look();
            chk($sformatf("stall_sel%0d", j), {6'b0, s1, s0}, 8'd0);
            chk($sformatf("stall_hold%0d", j), {7'b0, ser_out}, 8'd1);
            chk($sformatf("stall_valid%0d", j), {7'b0, ser_valid}, 8'd1);
            chk($sformatf("stall_apar%0d", j), {4'b0, A_par}, 8'b0011);
            chk($sformatf("stall_nodone%0d", j), {7'b0, done}, 8'd0);
            tick();
        end
        ser_ready = 1'b1;
        look();
        chk("stall_bit1", {7'b0, ser_out}, 8'd1);
        chk("stall_bit1_sel", {6'b0, s1, s0}, 8'd1);
        tick();
        look();
        chk("stall_bit2", {7'b0, ser_out}, 8'd1);
        chk("stall_nodone_b2", {7'b0, done}, 8'd0);
        tick();
        look();
        chk("stall_bit3", {7'b0, ser_out}, 8'd0);
        chk("stall_nodone_b3", {7'b0, done}, 8'd0);
        tick();
        look();
        chk("stall_done_late", {7'b0, done}, 8'd1);
        chk("stall_final", {4'b0, A_par}, 8'd0);
        tick();
        look();
        chk("stall_idle", {7'b0, cmd_ready}, 8'd1);

        // busy rejection and back-to-back acceptance with cmd_valid held high
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 4'b0001;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        look();
        tick();
        cmd_data = 4'b1000;
        look();
        chk("b2b_load_ready", {7'b0, cmd_ready}, 8'd0);
        chk("b2b_load_ipar", {4'b0, I_par}, 8'b0001);
        exp_b = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            tick();
            look();
            chk($sformatf("b2b_ready%0d", i), {7'b0, cmd_ready}, 8'd0);
            chk($sformatf("b2b_ipar%0d", i), {4'b0, I_par}, 8'b0001);
            chk($sformatf("b2b_bit%0d", i), {7'b0, ser_out}, {7'b0, exp_b[i]});
        end
        tick();
        look();
        chk("b2b_done", {7'b0, done}, 8'd1);
        chk("b2b_done_ready", {7'b0, cmd_ready}, 8'd0);
        chk("b2b_done_ipar", {4'b0, I_par}, 8'b0001);
        tick();
        look();
        chk("b2b_idle_ready", {7'b0, cmd_ready}, 8'd1);
        tick();
        cmd_valid = 1'b0;
        look();
        chk("b2b2_load_sel", {6'b0, s1, s0}, 8'd3);
        chk("b2b2_ipar", {4'b0, I_par}, 8'b1000);
        exp_b = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            tick();
            look();
            chk($sformatf("b2b2_bit%0d", i), {7'b0, ser_out}, {7'b0, exp_b[i]});
        end
        tick();
        look();
        chk("b2b2_done", {7'b0, done}, 8'd1);
        chk("b2b2_final", {4'b0, A_par}, 8'd0);
        tick();
        look();

        // reset mid-SHIFT after the 2nd bit
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 4'b1010;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b0;
        look();
        tick();
        cmd_valid = 1'b0;
        look();
        tick();
        look();
        chk("mid_bit0", {7'b0, ser_out}, 8'd0);
        tick();
        look();
        chk("mid_bit1", {7'b0, ser_out}, 8'd1);
        tick();
        Clear = 1'b1;
        look();
        chk("mid_clr_ready", {7'b0, cmd_ready}, 8'd0);
        chk("mid_clr_sel", {6'b0, s1, s0}, 8'd0);
        chk("mid_clr_valid", {7'b0, ser_valid}, 8'd0);
        chk("mid_clr_done", {7'b0, done}, 8'd0);
        chk("mid_clr_busy", {7'b0, busy}, 8'd0);
        tick();
        Clear = 1'b0;
        look();
        chk("mid_after_ready", {7'b0, cmd_ready}, 8'd1);
        chk("mid_after_sel", {6'b0, s1, s0}, 8'd0);
        chk("mid_after_valid", {7'b0, ser_valid}, 8'd0);
        chk("mid_after_busy", {7'b0, busy}, 8'd0);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("mid_nodone%0d", j), {7'b0, done}, 8'd0);
            tick();
            look();
        end

        // reset during LOAD: the 1111 load must never reach the register
        chk("ld_pre_apar", {4'b0, A_par}, 8'd0);
        tick();
        cmd_valid = 1'b1;
        cmd_data  = 4'b1111;
        cmd_dir   = 1'b0;
        cmd_fill  = 1'b1;
        look();
        tick();
        cmd_valid = 1'b0;
        Clear     = 1'b1;
        look();
        chk("ld_clr_sel", {6'b0, s1, s0}, 8'd0);
        chk("ld_clr_ready", {7'b0, cmd_ready}, 8'd0);
        chk("ld_clr_busy", {7'b0, busy}, 8'd0);
        tick();
        Clear = 1'b0;
        look();
        chk("ld_after_apar", {4'b0, A_par}, 8'd0);
        chk("ld_after_ready", {7'b0, cmd_ready}, 8'd1);
        chk("ld_after_sel", {6'b0, s1, s0}, 8'd0);
        tick();
        look();
        chk("ld_after2_apar", {4'b0, A_par}, 8'd0);
        chk("ld_after2_valid", {7'b0, ser_valid}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
